tomasulo_exec_units: RTL and testbench

Execution back-end of the Tomasulo core: one free-running 21-bit issue-time counter plus two independent 9-bit functional units. The add/sub unit and the mul/div unit each accept one operation from the reservation-station controller. Each unit returns the result together with the destination register address and the reservation-station label that issued it. The controller uses the time stamps to order issue and to arbitrate simultaneous completions.

---
 rtl/tomasulo_pkg.sv | 34 +++
 rtl/tomasulo_fu.sv | 109 ++++++++++
 rtl/tomasulo_exec_units.sv | 93 +++++++++
 tb/tb_tomasulo_exec_units.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared widths, opcodes and types for the Tomasulo execution back-end.
// The divider is built only when TOMASULO_DIV_EN is defined.
package tomasulo_pkg;

   localparam int unsigned DW = 9;
   localparam int unsigned TW = 21;
   localparam int unsigned RW = 3;

   localparam logic [2:0] SOM = 3'b000;
   localparam logic [2:0] SUB = 3'b001;
   localparam logic [2:0] MUL = 3'b010;
   localparam logic [2:0] DIV = 3'b011;

   localparam logic [DW-1:0] NOT_READY = 9'h1FF;

   typedef enum logic {ADDSUB, MULDIV} fu_kind_e;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} fu_state_e;

   // Operation captured at start; alt selects sub (add/sub unit) or div (mul/div unit)
   typedef struct packed {
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic          alt;
      logic [RW-1:0] dest;
      logic [RW-1:0] label;
   } fu_req_t;

   // Only the low opcode bit distinguishes the two operations of a unit
   function automatic logic opAlt(input logic [2:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/tomasulo_fu.sv
// One functional unit (add/sub or mul/div) with IDLE/BUSY/DONE sequencing.
// Division hardware exists only when TOMASULO_DIV_EN is defined.
module tomasulo_fu
   import tomasulo_pkg::*;
#(
   parameter fu_kind_e    KIND  = ADDSUB,
   parameter int unsigned LAT_A = 2,
   parameter int unsigned LAT_B = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] y,
   input  logic [2:0]    op,
   input  logic [RW-1:0] destIn,
   input  logic [RW-1:0] labelIn,
   output logic [DW-1:0] result,
   output logic          done,
   output logic [RW-1:0] destOut,
   output logic [RW-1:0] labelOut
);

   localparam int unsigned MAX_LAT = (LAT_A > LAT_B) ? LAT_A : LAT_B;
   localparam int unsigned CW      = $clog2(MAX_LAT + 1);

   fu_state_e     state;
   fu_state_e     stateNext;
   logic [CW-1:0] cnt;
   fu_req_t       req;
   logic          capture;
   logic          complete;
   logic          startAlt;
   logic [DW-1:0] calcResult;

   assign startAlt = opAlt(op);

   // Next-state and control strobes
   always_comb begin
      stateNext = state;
      capture   = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (run) begin
               capture   = 1'b1;
               stateNext = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               complete  = 1'b1;
               stateNext = DONE;
            end
         end
         DONE: begin
            if (run) begin
               capture   = 1'b1;
               stateNext = BUSY;
            end else begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Datapath on captured operands; a zero divisor leaves the result at 0
   always_comb begin
      calcResult = '0;
      if (KIND == ADDSUB) begin
         calcResult = req.alt ? (req.x - req.y) : (req.x + req.y);
      end else if (!req.alt) begin
         calcResult = req.x * req.y;
      end
`ifdef TOMASULO_DIV_EN
      else if (req.y != '0) begin
         calcResult = req.x / req.y;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         req      <= '0;
         result   <= '0;
         done     <= 1'b0;
         destOut  <= '0;
         labelOut <= '0;
      end else begin
         state <= stateNext;
         done  <= (stateNext == DONE);
         if (capture) begin
            req <= '{x: x, y: y, alt: startAlt, dest: destIn, label: labelIn};
            cnt <= startAlt ? CW'(LAT_B - 1) : CW'(LAT_A - 1);
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (complete) begin
            result   <= calcResult;
            destOut  <= req.dest;
            labelOut <= req.label;
         end
      end
   end

endmodule

// File: rtl/tomasulo_exec_units.sv
// Tomasulo execution back-end: free-running issue-time counter plus independent
// add/sub and mul/div units. TOMASULO_DIV_EN enables the divider.
module tomasulo_exec_units
   import tomasulo_pkg::*;
#(
   parameter int unsigned ADD_LAT = 2,
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [TW-1:0] time_o,
   input  logic          as_run,
   input  logic [DW-1:0] as_x,
   input  logic [DW-1:0] as_y,
   input  logic [2:0]    as_op,
   input  logic [RW-1:0] as_dest_in,
   input  logic [RW-1:0] as_label_in,
   output logic [DW-1:0] as_result,
   output logic          as_done,
   output logic [RW-1:0] as_dest_out,
   output logic [RW-1:0] as_label_out,
   input  logic          md_run,
   input  logic [DW-1:0] md_x,
   input  logic [DW-1:0] md_y,
   input  logic [2:0]    md_op,
   input  logic [RW-1:0] md_dest_in,
   input  logic [RW-1:0] md_label_in,
   output logic [DW-1:0] md_result,
   output logic          md_done,
   output logic [RW-1:0] md_dest_out,
   output logic [RW-1:0] md_label_out
);

   if (ADD_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
      $error("tomasulo_exec_units: latencies must be >= 1");
   end

`ifdef TOMASULO_DIV_EN
   localparam int unsigned MD_ALT_LAT = DIV_LAT;
`else
   // Without a divider a div op completes on the multiply timeline with result 0
   localparam int unsigned MD_ALT_LAT = MUL_LAT;
`endif

   // Issue-time counter, wraps naturally at 2^TW
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         time_o <= '0;
      end else begin
         time_o <= time_o + TW'(1);
      end
   end

   tomasulo_fu #(
      .KIND  (ADDSUB),
      .LAT_A (ADD_LAT),
      .LAT_B (ADD_LAT)
   ) u_addsub (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (as_run),
      .x        (as_x),
      .y        (as_y),
      .op       (as_op),
      .destIn   (as_dest_in),
      .labelIn  (as_label_in),
      .result   (as_result),
      .done     (as_done),
      .destOut  (as_dest_out),
      .labelOut (as_label_out)
   );

   tomasulo_fu #(
      .KIND  (MULDIV),
      .LAT_A (MUL_LAT),
      .LAT_B (MD_ALT_LAT)
   ) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (md_run),
      .x        (md_x),
      .y        (md_y),
      .op       (md_op),
      .destIn   (md_dest_in),
      .labelIn  (md_label_in),
      .result   (md_result),
      .done     (md_done),
      .destOut  (md_dest_out),
      .labelOut (md_label_out)
   );

endmodule

// File: tb/tb_tomasulo_exec_units.sv
// Scoreboard bench for tomasulo_exec_units: directed ops push expectations,
// per-unit monitors pop and compare on every done pulse.
module tb_tomasulo_exec_units;
   import tomasulo_pkg::*;

   localparam int unsigned ADD_LAT = 2;
   localparam int unsigned MUL_LAT = 4;
   localparam int unsigned DIV_LAT = 8;
`ifdef TOMASULO_DIV_EN
   localparam int unsigned DIVL = DIV_LAT;
   localparam logic [DW-1:0] DIV_Q = 9'd14;
`else
   localparam int unsigned DIVL = MUL_LAT;
   localparam logic [DW-1:0] DIV_Q = 9'd0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [TW-1:0] time_o;
   logic          as_run, md_run;
   logic [DW-1:0] as_x, as_y, md_x, md_y;
   logic [2:0]    as_op, md_op;
   logic [RW-1:0] as_dest_in, as_label_in, md_dest_in, md_label_in;
   logic [DW-1:0] as_result, md_result;
   logic          as_done, md_done;
   logic [RW-1:0] as_dest_out, as_label_out, md_dest_out, md_label_out;

   typedef struct {
      logic [DW-1:0] res;
      logic [RW-1:0] dest;
      logic [RW-1:0] label;
      int unsigned   cyc;
   } exp_t;

   exp_t        asQ[$];
   exp_t        mdQ[$];
   int          vecs = 0;
   int          errs = 0;
   int unsigned cyc  = 0;

   tomasulo_exec_units #(
      .ADD_LAT (ADD_LAT),
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .time_o       (time_o),
      .as_run       (as_run),
      .as_x         (as_x),
      .as_y         (as_y),
      .as_op        (as_op),
      .as_dest_in   (as_dest_in),
      .as_label_in  (as_label_in),
      .as_result    (as_result),
      .as_done      (as_done),
      .as_dest_out  (as_dest_out),
      .as_label_out (as_label_out),
      .md_run       (md_run),
      .md_x         (md_x),
      .md_y         (md_y),
      .md_op        (md_op),
      .md_dest_in   (md_dest_in),
      .md_label_in  (md_label_in),
      .md_result    (md_result),
      .md_done      (md_done),
      .md_dest_out  (md_dest_out),
      .md_label_out (md_label_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (as_done === 1'b1) begin
         if (asQ.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL as_unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = asQ.pop_front();
            check("as_result", 32'(as_result), 32'(e.res));
            check("as_dest_out", 32'(as_dest_out), 32'(e.dest));
            check("as_label_out", 32'(as_label_out), 32'(e.label));
            check("as_done_cycle", cyc, e.cyc);
         end
      end
      if (md_done === 1'b1) begin
         if (mdQ.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL md_unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = mdQ.pop_front();
            check("md_result", 32'(md_result), 32'(e.res));
            check("md_dest_out", 32'(md_dest_out), 32'(e.dest));
            check("md_label_out", 32'(md_label_out), 32'(e.label));
            check("md_done_cycle", cyc, e.cyc);
         end
      end
   end

   // Called at a negedge; capture happens on the next rising edge
   task automatic issueAs(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [2:0] op,
                          input logic [RW-1:0] dest, input logic [RW-1:0] label,
                          input logic [DW-1:0] res);
      as_run = 1'b1; as_x = x; as_y = y; as_op = op; as_dest_in = dest; as_label_in = label;
      asQ.push_back('{res, dest, label, cyc + 1 + ADD_LAT});
      @(negedge clk);
      as_run = 1'b0;
   endtask

   task automatic issueMd(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [2:0] op,
                          input logic [RW-1:0] dest, input logic [RW-1:0] label,
                          input logic [DW-1:0] res, input int unsigned lat);
      md_run = 1'b1; md_x = x; md_y = y; md_op = op; md_dest_in = dest; md_label_in = label;
      mdQ.push_back('{res, dest, label, cyc + 1 + lat});
      @(negedge clk);
      md_run = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((asQ.size() != 0 || mdQ.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(asQ.size() + mdQ.size()), 32'd0);
      asQ.delete();
      mdQ.delete();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      as_run = 1'b0; as_x = '0; as_y = '0; as_op = '0; as_dest_in = '0; as_label_in = '0;
      md_run = 1'b0; md_x = '0; md_y = '0; md_op = '0; md_dest_in = '0; md_label_in = '0;
      repeat (2) @(negedge clk);
      check("rst_time", 32'(time_o), 32'd0);
      check("rst_as_done", 32'(as_done), 32'd0);
      check("rst_md_done", 32'(md_done), 32'd0);
      check("rst_as_result", 32'(as_result), 32'd0);
      check("rst_md_result", 32'(md_result), 32'd0);
      check("rst_labels", 32'({as_dest_out, as_label_out, md_dest_out, md_label_out}), 32'd0);

      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 check("time_after_10", 32'(time_o), 32'd10);

      @(negedge clk);
      force dut.time_o = 21'h1FFFFF;
      #1 release dut.time_o;
      @(posedge clk);
      #1 check("time_wrap", 32'(time_o), 32'd0);
      @(posedge clk);
      #1 check("time_after_wrap", 32'(time_o), 32'd1);
      @(negedge clk);

      issueAs(9'd5, 9'd7, SOM, 3'd2, 3'd1, 9'd12);
      drain("drain_add");
      issueAs(9'd3, 9'd5, SUB, 3'd3, 3'd2, 9'h1FE);
      drain("drain_sub");
      issueAs(9'd10, 9'd3, 3'b101, 3'd1, 3'd0, 9'd7);
      drain("drain_sub_hi_op");

      issueMd(9'd30, 9'd20, MUL, 3'd4, 3'd3, 9'd88, MUL_LAT);
      drain("drain_mul");
      issueMd(9'd100, 9'd7, DIV, 3'd5, 3'd4, DIV_Q, DIVL);
      drain("drain_div");
      issueMd(9'd9, 9'd0, DIV, 3'd6, 3'd5, 9'd0, DIVL);
      drain("drain_div0");

      // Add issued two cycles after a mul: both complete in the same cycle
      issueMd(9'd6, 9'd7, MUL, 3'd1, 3'd3, 9'd42, MUL_LAT);
      @(negedge clk);
      issueAs(9'd100, 9'd200, SOM, 3'd2, 3'd0, 9'd300);
      drain("drain_concurrent");

      // Run held high for three ops, operands scrambled while busy
      for (int k = 0; k < 3; k++) begin
         as_run = 1'b1;
         case (k)
            0: begin as_x = 9'd1;   as_y = 9'd2;   as_op = SOM; as_dest_in = 3'd1; as_label_in = 3'd0; end
            1: begin as_x = 9'd20;  as_y = 9'd5;   as_op = SUB; as_dest_in = 3'd2; as_label_in = 3'd1; end
            default: begin as_x = 9'd250; as_y = 9'd300; as_op = SOM; as_dest_in = 3'd3; as_label_in = 3'd2; end
         endcase
         case (k)
            0: asQ.push_back('{9'd3, 3'd1, 3'd0, cyc + 1 + ADD_LAT});
            1: asQ.push_back('{9'd15, 3'd2, 3'd1, cyc + 1 + ADD_LAT});
            default: asQ.push_back('{9'd38, 3'd3, 3'd2, cyc + 1 + ADD_LAT});
         endcase
         @(negedge clk);
         if (k == 2) as_run = 1'b0;
         as_x = '1; as_y = '1; as_op = SUB; as_dest_in = 3'd7; as_label_in = 3'd7;
         @(negedge clk);
         as_x = 9'd77; as_y = 9'd11;
         @(negedge clk);
      end
      drain("drain_b2b");

      // Reset in the middle of a divide aborts it without a done pulse
      issueMd(9'd200, 9'd3, DIV, 3'd7, 3'd5, 9'd0, DIVL);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      mdQ.delete();
      #1;
      check("midrst_md_result", 32'(md_result), 32'd0);
      check("midrst_md_tags", 32'({md_dest_out, md_label_out}), 32'd0);
      check("midrst_as_result", 32'(as_result), 32'd0);
      check("midrst_as_tags", 32'({as_dest_out, as_label_out}), 32'd0);
      check("midrst_time", 32'(time_o), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("postrst_md_result", 32'(md_result), 32'd0);
      issueMd(9'd3, 9'd4, MUL, 3'd7, 3'd5, 9'd12, MUL_LAT);
      drain("drain_post_reset_mul");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
